decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Decodes one RV32-style fetch word per accepted handshake into a registered
// bundle of operand indices, immediates and control flags. A per-register
// down-counter scoreboard tracks multi-cycle results (multiply, load) and
// blocks issue of an instruction that reads a still-busy register.
//
// Handshake: a word moves from fetch into this stage on a rising edge where
// F_valid && F_ready && !D_flush. The decoded bundle moves on to execute on a
// rising edge where D_valid && X_ready. While D_valid && !X_ready every output
// is held and F_ready is low. F_ready never looks at F_valid.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   F_valid           fetch word valid
//   F_instruction     fetch word
//   F_pc              pc of the fetch word
//   F_ready           stage accepts the fetch word this cycle (combinational)
//   X_ready           execute accepts the current decoded bundle
//   D_flush           drop the held bundle and any incoming word
//   D_valid           decoded bundle valid
//   D_addr_r1/_r2     source register indices
//   D_dest            destination register index
//   D_immediate       sign-extended immediate
//   D_bImmediate      branch target (B) or link value (J/JAL)
//   D_We, D_op, D_Ie, D_b, is_mul, is_alu, D_is_load, D_is_store, D_illegal
//                     control flags
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int ADDRESS_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int MUL_LATENCY      = 5,
  parameter int LOAD_LATENCY     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        F_valid,
  input  logic [ADDRESS_SIZE-1:0]     F_instruction,
  input  logic [ADDRESS_SIZE-1:0]     F_pc,
  output logic                        F_ready,
  input  logic                        X_ready,
  input  logic                        D_flush,
  output logic                        D_valid,
  output logic [REG_ADDRESS_SIZE-1:0] D_addr_r1,
  output logic [REG_ADDRESS_SIZE-1:0] D_addr_r2,
  output logic [REG_ADDRESS_SIZE-1:0] D_dest,
  output logic [ADDRESS_SIZE-1:0]     D_immediate,
  output logic [ADDRESS_SIZE-1:0]     D_bImmediate,
  output logic                        D_We,
  output logic                        D_op,
  output logic                        D_Ie,
  output logic                        D_b,
  output logic                        is_mul,
  output logic                        is_alu,
  output logic                        D_is_load,
  output logic                        D_is_store,
  output logic                        D_illegal
);

  localparam int NREGS   = 1 << REG_ADDRESS_SIZE;
  localparam int MAX_LAT = (MUL_LATENCY > LOAD_LATENCY) ? MUL_LATENCY : LOAD_LATENCY;
  localparam int CW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

  localparam logic [6:0] OP_RR  = 7'b0110011;
  localparam logic [6:0] OP_IR  = 7'b0010011;
  localparam logic [6:0] OP_SR  = 7'b0100011;
  localparam logic [6:0] OP_LR  = 7'b0000011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1100111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef struct packed {
    logic [REG_ADDRESS_SIZE-1:0] r1;
    logic [REG_ADDRESS_SIZE-1:0] r2;
    logic [REG_ADDRESS_SIZE-1:0] dest;
    logic [ADDRESS_SIZE-1:0]     imm;
    logic [ADDRESS_SIZE-1:0]     bimm;
    logic                        we;
    logic                        op;
    logic                        ie;
    logic                        b;
    logic                        mul;
    logic                        alu;
    logic                        load;
    logic                        store;
    logic                        illegal;
  } dec_t;

  dec_t            dec_now;
  dec_t            dec_d, dec_q;
  logic            valid_d, valid_q;
  logic            use_r1, use_r2;
  logic            hazard;
  logic            accept;
  logic [6:0]      opcode;
  logic [ADDRESS_SIZE-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [CW-1:0]   cnt_d [NREGS];
  logic [CW-1:0]   cnt_q [NREGS];

  // Immediate formats; the sized cast of a signed slice sign-extends from inst[31].
  assign opcode = F_instruction[6:0];
  assign imm_i  = ADDRESS_SIZE'($signed(F_instruction[31:20]));
  assign imm_s  = ADDRESS_SIZE'($signed({F_instruction[31:25], F_instruction[11:7]}));
  assign imm_b  = ADDRESS_SIZE'($signed({F_instruction[31], F_instruction[7],
                                         F_instruction[30:25], F_instruction[11:8], 1'b0}));
  assign imm_j  = ADDRESS_SIZE'($signed({F_instruction[31], F_instruction[19:12],
                                         F_instruction[20], F_instruction[30:21], 1'b0}));
  assign imm_u  = ADDRESS_SIZE'($signed({F_instruction[31:12], 12'b0}));

  // Combinational decode of the incoming fetch word.
  always_comb begin
    dec_now      = '0;
    use_r1       = 1'b0;
    use_r2       = 1'b0;
    dec_now.r1   = REG_ADDRESS_SIZE'(F_instruction[19:15]);
    dec_now.r2   = REG_ADDRESS_SIZE'(F_instruction[24:20]);
    dec_now.dest = REG_ADDRESS_SIZE'(F_instruction[11:7]);
    case (opcode)
      OP_RR: begin
        dec_now.we  = 1'b1;
        dec_now.op  = F_instruction[30];
        dec_now.mul = F_instruction[25];
        use_r1      = 1'b1;
        use_r2      = 1'b1;
      end
      OP_IR: begin
        dec_now.we  = 1'b1;
        dec_now.ie  = 1'b1;
        dec_now.imm = imm_i;
        use_r1      = 1'b1;
      end
      OP_SR: begin
        dec_now.ie    = 1'b1;
        dec_now.imm   = imm_s;
        dec_now.store = 1'b1;
        use_r1        = 1'b1;
        use_r2        = 1'b1;
      end
      OP_LR: begin
        dec_now.we   = 1'b1;
        dec_now.ie   = 1'b1;
        dec_now.imm  = imm_i;
        dec_now.load = 1'b1;
        use_r1       = 1'b1;
      end
      OP_B: begin
        dec_now.op   = 1'b1;
        dec_now.b    = 1'b1;
        dec_now.imm  = imm_b;
        dec_now.bimm = F_pc + imm_b;
        use_r1       = 1'b1;
        use_r2       = 1'b1;
      end
      OP_J: begin
        dec_now.we   = 1'b1;
        dec_now.ie   = 1'b1;
        dec_now.b    = 1'b1;
        dec_now.imm  = imm_i;
        dec_now.bimm = F_pc + ADDRESS_SIZE'(4);
        use_r1       = 1'b1;
      end
      OP_JAL: begin
        dec_now.we   = 1'b1;
        dec_now.ie   = 1'b1;
        dec_now.b    = 1'b1;
        dec_now.imm  = imm_j;
        dec_now.bimm = F_pc + ADDRESS_SIZE'(4);
      end
      OP_LUI: begin
        dec_now.we  = 1'b1;
        dec_now.ie  = 1'b1;
        dec_now.imm = imm_u;
      end
      default: begin
        dec_now.illegal = 1'b1;
      end
    endcase
    // Illegal words carry no control at all, including is_alu.
    dec_now.alu = !dec_now.illegal && !dec_now.mul;
    // x0 is hardwired: never a real write, never tracked.
    if (dec_now.dest == '0) dec_now.we = 1'b0;
  end

  assign hazard  = (use_r1 && (cnt_q[dec_now.r1] != '0)) ||
                   (use_r2 && (cnt_q[dec_now.r2] != '0));
  assign F_ready = (!valid_q || X_ready) && !hazard;
  assign accept  = F_valid && F_ready && !D_flush;

  // Output register next state.
  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec_now;
    end else if (D_flush || (valid_q && X_ready)) begin
      valid_d = 1'b0;
    end
  end

  // Scoreboard next state: every busy counter ticks down; a new issue to the
  // same register overrides the tick. A flush stops the incoming word from
  // setting anything but leaves in-flight results counting down.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
    end
    if (accept && dec_now.we) begin
      if (dec_now.mul)       cnt_d[dec_now.dest] = CW'(MUL_LATENCY);
      else if (dec_now.load) cnt_d[dec_now.dest] = CW'(LOAD_LATENCY);
      else                   cnt_d[dec_now.dest] = '0;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign D_valid      = valid_q;
  assign D_addr_r1    = dec_q.r1;
  assign D_addr_r2    = dec_q.r2;
  assign D_dest       = dec_q.dest;
  assign D_immediate  = dec_q.imm;
  assign D_bImmediate = dec_q.bimm;
  assign D_We         = dec_q.we;
  assign D_op         = dec_q.op;
  assign D_Ie         = dec_q.ie;
  assign D_b          = dec_q.b;
  assign is_mul       = dec_q.mul;
  assign is_alu       = dec_q.alu;
  assign D_is_load    = dec_q.load;
  assign D_is_store   = dec_q.store;
  assign D_illegal    = dec_q.illegal;

endmodule
